// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
// Holds the arbiter FSM state encoding, the requester owner encoding and the
// default memory geometry (word width, address width, depth, latency counter).
package dmem_pkg;
    localparam int DMEM_DATA_W = 64;
    localparam int DMEM_ADDR_W = 64;
    localparam int DMEM_DEPTH  = 32;
    localparam int DMEM_CNT_W  = 2;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_DBG = 1'b1} owner_t;
endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// rr_arbiter2: 2-way round-robin grant with a last_grant register.
// Ports: i_clk, i_rst_n (async active-low), i_req[1:0] (bit0=CPU, bit1=DBG),
//        i_en (commit the grant this cycle), o_gnt (winning owner),
//        o_any (some request present).
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output owner_t     o_gnt,
    output logic       o_any
);
    owner_t r_last;

    assign o_any = |i_req;
    // On contention the port that did not win last time goes first.
    assign o_gnt = &i_req ? ((r_last == OWN_CPU) ? OWN_DBG : OWN_CPU)
                          : (i_req[1] ? OWN_DBG : OWN_CPU);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_last <= OWN_DBG;
        else if (i_en && o_any)
            r_last <= o_gnt;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the CPU and debug ports.
// Ports: i_clk, i_rst_n (async active-low);
//        i_cpu_req_* / o_cpu_req_ready / o_cpu_rsp_* : CPU load/store port;
//        i_dbg_req_* / o_dbg_req_ready / o_dbg_rsp_* : debug/DMA port;
//        o_mem_addr, o_mem_wdata, o_mem_read, o_mem_write, i_mem_rdata : memory side.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int MEM_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_req_valid,
    output logic              o_cpu_req_ready,
    input  logic              i_cpu_req_write,
    input  logic [ADDR_W-1:0] i_cpu_req_addr,
    input  logic [DATA_W-1:0] i_cpu_req_wdata,
    output logic              o_cpu_rsp_valid,
    output logic [DATA_W-1:0] o_cpu_rsp_rdata,
    output logic              o_cpu_rsp_err,
    input  logic              i_dbg_req_valid,
    output logic              o_dbg_req_ready,
    input  logic              i_dbg_req_write,
    input  logic [ADDR_W-1:0] i_dbg_req_addr,
    input  logic [DATA_W-1:0] i_dbg_req_wdata,
    output logic              o_dbg_rsp_valid,
    output logic [DATA_W-1:0] o_dbg_rsp_rdata,
    output logic              o_dbg_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    state_t                r_state;
    owner_t                r_owner;
    logic                  r_write;
    logic                  r_err;
    logic [DMEM_CNT_W-1:0] r_cnt;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;
    owner_t                w_gnt;
    logic                  w_any;
    logic                  w_take;
    logic                  w_sel_write;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic                  w_sel_oob;

    rr_arbiter2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   ({i_dbg_req_valid, i_cpu_req_valid}),
        .i_en    (w_take),
        .o_gnt   (w_gnt),
        .o_any   (w_any)
    );

    // Ready is gated by reset so every output reads 0 while rst_n is low.
    assign w_take          = i_rst_n && (r_state == IDLE) && w_any;
    assign o_cpu_req_ready = w_take && (w_gnt == OWN_CPU);
    assign o_dbg_req_ready = w_take && (w_gnt == OWN_DBG);
    assign w_sel_write     = (w_gnt == OWN_DBG) ? i_dbg_req_write : i_cpu_req_write;
    assign w_sel_addr      = (w_gnt == OWN_DBG) ? i_dbg_req_addr  : i_cpu_req_addr;
    assign w_sel_wdata     = (w_gnt == OWN_DBG) ? i_dbg_req_wdata : i_cpu_req_wdata;
    // Full-width compare: high address bits are never dropped.
    assign w_sel_oob       = w_sel_addr >= ADDR_W'(DEPTH);

    assign o_cpu_rsp_valid = r_rsp_valid && (r_owner == OWN_CPU);
    assign o_dbg_rsp_valid = r_rsp_valid && (r_owner == OWN_DBG);
    assign o_cpu_rsp_rdata = o_cpu_rsp_valid ? r_rsp_rdata : '0;
    assign o_dbg_rsp_rdata = o_dbg_rsp_valid ? r_rsp_rdata : '0;
    assign o_cpu_rsp_err   = o_cpu_rsp_valid && r_err;
    assign o_dbg_rsp_err   = o_dbg_rsp_valid && r_err;

    // Strobes and address are registered at the grant edge so they are
    // asserted for the whole ISSUE cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_owner     <= OWN_CPU;
            r_write     <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_take) begin
                    r_state     <= ISSUE;
                    r_owner     <= w_gnt;
                    r_write     <= w_sel_write;
                    r_err       <= w_sel_oob;
                    r_cnt       <= DMEM_CNT_W'(MEM_LAT - 1);
                    o_mem_addr  <= w_sel_addr;
                    o_mem_wdata <= w_sel_wdata;
                    o_mem_read  <= !w_sel_write && !w_sel_oob;
                    o_mem_write <= w_sel_write && !w_sel_oob;
                end
                ISSUE: begin
                    o_mem_write <= 1'b0;
                    if (r_err || r_write || MEM_LAT == 1) begin
                        r_state     <= RESP;
                        o_mem_read  <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= (r_err || r_write) ? '0 : i_mem_rdata;
                    end else begin
                        r_state <= WAIT;
                        r_cnt   <= r_cnt - DMEM_CNT_W'(1);
                    end
                end
                WAIT: if (r_cnt == '0) begin
                    r_state     <= RESP;
                    o_mem_read  <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= i_mem_rdata;
                end else begin
                    r_cnt <= r_cnt - DMEM_CNT_W'(1);
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
